// File: rtl/snake_pkg.sv
// Shared types and constants for the score UART reporter.
package snake_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        SEND = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } tx_state_t;

    localparam logic [7:0]  ASCII_ZERO = 8'h30;
    localparam logic [7:0]  ASCII_EQ   = 8'h3D;
    localparam logic [7:0]  ASCII_CR   = 8'h0D;
    localparam logic [7:0]  ASCII_LF   = 8'h0A;
    localparam logic [7:0]  ASCII_BAD  = 8'h3F;
    localparam int unsigned LINE_LEN   = 7;
    // Index of the final byte of a line (the LF).
    localparam logic [2:0]  LAST_IDX   = 3'(LINE_LEN - 1);

endpackage

// File: rtl/score_uart_reporter_if.sv
// Request / UART-side signal bundle of the score reporter.
interface score_uart_reporter_if;

    logic [3:0] bcd_hundreds;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       send_score;
    logic       send_high;
    logic       txready;
    logic [7:0] txdata;
    logic       txclk;
    logic       busy;
    logic       line_done;

    // Reporter side: takes digits and requests, drives the UART byte port.
    modport master (
        input  bcd_hundreds, bcd_tens, bcd_ones,
        input  send_score, send_high, txready,
        output txdata, txclk, busy, line_done
    );

    // Surrounding logic side: supplies digits and requests, consumes bytes.
    modport slave (
        output bcd_hundreds, bcd_tens, bcd_ones,
        output send_score, send_high, txready,
        input  txdata, txclk, busy, line_done
    );

endinterface

// File: rtl/bcd_to_ascii.sv
// One BCD digit to its ASCII character; out-of-range digits become '?'.
module bcd_to_ascii
    import snake_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] ascii
);

    // Digits 0..9 map onto '0'..'9'; anything above 9 is flagged as '?'.
    always_comb begin
        if (digit <= 4'd9) begin
            ascii = ASCII_ZERO + {4'h0, digit};
        end else begin
            ascii = ASCII_BAD;
        end
    end

endmodule

// File: rtl/score_uart_reporter.sv
// Serialises a 3-digit BCD score or high score as "T=ddd\r\n" onto a
// byte-wide UART load port. Requests are latched one deep per kind so a
// strobe arriving mid-line is reported once the current line finishes.
module score_uart_reporter
    import snake_pkg::*;
#(
    parameter logic [7:0]  TAG_SCORE  = 8'h53,
    parameter logic [7:0]  TAG_HIGH   = 8'h48,
    parameter int unsigned GAP_CYCLES = 1
)(
    input logic                   clk,
    input logic                   nRst,
    score_uart_reporter_if.master bus
);

    // Last value of the gap counter before returning to SEND.
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    tx_state_t  state_r,      state_s;
    logic       pend_score_r, pend_score_s;
    logic       pend_high_r,  pend_high_s;
    logic [2:0] idx_r,        idx_s;
    logic [3:0] gap_r,        gap_s;
    logic [7:0] tag_r,        tag_s;
    logic [3:0] hun_r,        hun_s;
    logic [3:0] ten_r,        ten_s;
    logic [3:0] one_r,        one_s;
    logic [7:0] txdata_r,     txdata_s;
    logic       txclk_r,      txclk_s;
    logic       busy_r,       busy_s;
    logic       line_done_r,  line_done_s;

    logic [7:0] hun_ascii_s;
    logic [7:0] ten_ascii_s;
    logic [7:0] one_ascii_s;
    logic [7:0] line_byte_s;

    bcd_to_ascii u_hun (.digit(hun_r), .ascii(hun_ascii_s));
    bcd_to_ascii u_ten (.digit(ten_r), .ascii(ten_ascii_s));
    bcd_to_ascii u_one (.digit(one_r), .ascii(one_ascii_s));

    // Select the byte of the snapshotted line at the current index.
    always_comb begin
        case (idx_r)
            3'd0:    line_byte_s = tag_r;
            3'd1:    line_byte_s = ASCII_EQ;
            3'd2:    line_byte_s = hun_ascii_s;
            3'd3:    line_byte_s = ten_ascii_s;
            3'd4:    line_byte_s = one_ascii_s;
            3'd5:    line_byte_s = ASCII_CR;
            3'd6:    line_byte_s = ASCII_LF;
            default: line_byte_s = ASCII_BAD;
        endcase
    end

    // Next-state, request latching and output decisions.
    always_comb begin
        state_s      = state_r;
        pend_score_s = pend_score_r | bus.send_score;
        pend_high_s  = pend_high_r  | bus.send_high;
        idx_s        = idx_r;
        gap_s        = gap_r;
        tag_s        = tag_r;
        hun_s        = hun_r;
        ten_s        = ten_r;
        one_s        = one_r;
        txdata_s     = txdata_r;
        txclk_s      = 1'b0;
        line_done_s  = 1'b0;

        case (state_r)
            IDLE: begin
                if (pend_score_s || pend_high_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                hun_s = bus.bcd_hundreds;
                ten_s = bus.bcd_tens;
                one_s = bus.bcd_ones;
                idx_s = 3'd0;
                gap_s = 4'd0;
                // High score wins when both are waiting; a fresh strobe of
                // the kind being cleared survives as a new request.
                if (pend_high_r) begin
                    tag_s       = TAG_HIGH;
                    pend_high_s = bus.send_high;
                end else begin
                    tag_s        = TAG_SCORE;
                    pend_score_s = bus.send_score;
                end
                state_s = SEND;
            end
            SEND: begin
                if (bus.txready) begin
                    txdata_s = line_byte_s;
                    txclk_s  = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s = DONE;
                    end else begin
                        idx_s   = idx_r + 3'd1;
                        state_s = GAP;
                    end
                end else begin
                    state_s = SEND;
                end
            end
            GAP: begin
                if (gap_r == GAP_LAST) begin
                    gap_s   = 4'd0;
                    state_s = SEND;
                end else begin
                    gap_s   = gap_r + 4'd1;
                    state_s = GAP;
                end
            end
            DONE: begin
                line_done_s = 1'b1;
                if (pend_score_s || pend_high_s) begin
                    state_s = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s = (state_s != IDLE) || pend_score_s || pend_high_s;
    end

    // State and output registers; reset abandons any line in progress.
    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_r      <= IDLE;
            pend_score_r <= 1'b0;
            pend_high_r  <= 1'b0;
            idx_r        <= 3'd0;
            gap_r        <= 4'd0;
            tag_r        <= 8'h00;
            hun_r        <= 4'd0;
            ten_r        <= 4'd0;
            one_r        <= 4'd0;
            txdata_r     <= 8'h00;
            txclk_r      <= 1'b0;
            busy_r       <= 1'b0;
            line_done_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            pend_score_r <= pend_score_s;
            pend_high_r  <= pend_high_s;
            idx_r        <= idx_s;
            gap_r        <= gap_s;
            tag_r        <= tag_s;
            hun_r        <= hun_s;
            ten_r        <= ten_s;
            one_r        <= one_s;
            txdata_r     <= txdata_s;
            txclk_r      <= txclk_s;
            busy_r       <= busy_s;
            line_done_r  <= line_done_s;
        end
    end

    assign bus.txdata    = txdata_r;
    assign bus.txclk     = txclk_r;
    assign bus.busy      = busy_r;
    assign bus.line_done = line_done_r;

endmodule

// File: tb/tb_score_uart_reporter.sv
// Scoreboard bench: stimulus pushes the expected bytes of each line (and a
// line_done marker) into a queue; a negedge monitor pops and compares.
module tb_score_uart_reporter;

    localparam int LD_MARK = 256;

    logic clk = 1'b0;
    logic nRst;

    score_uart_reporter_if bus();

    score_uart_reporter #(
        .TAG_SCORE (8'h53),
        .TAG_HIGH  (8'h48),
        .GAP_CYCLES(1)
    ) dut (
        .clk (clk),
        .nRst(nRst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         sb[$];
    int         strobe_cyc[$];
    int         ld_cyc[$];
    int         cyc      = 0;
    logic [7:0] last_data = 8'h00;
    bit         prev_txclk = 1'b0;

    // Free-running clock.
    always #5 clk = ~clk;

    // Cycle counter used for strobe spacing checks.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compare every strobe and line_done against the scoreboard.
    always @(negedge clk) begin
        if (nRst !== 1'b1) begin
            prev_txclk = 1'b0;
            last_data  = 8'h00;
        end else begin
            if (bus.txclk === 1'b1) begin
                chk("txclk_not_back_to_back", {31'd0, prev_txclk}, 32'd0);
                strobe_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got %0h expected none", bus.txdata);
                end else begin
                    chk("txdata", {24'd0, bus.txdata}, sb.pop_front());
                end
                last_data = bus.txdata;
            end else begin
                chk("txdata_hold", {24'd0, bus.txdata}, {24'd0, last_data});
            end
            if (bus.line_done === 1'b1) begin
                ld_cyc.push_back(cyc);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_line_done: got pulse expected none");
                end else begin
                    chk("line_done_order", LD_MARK, sb.pop_front());
                end
            end
            prev_txclk = (bus.txclk === 1'b1);
        end
    end

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue a hand-written 7-byte line followed by its line_done marker.
    task automatic push_line(input logic [55:0] bytes);
        for (int i = 0; i < 7; i++) begin
            sb.push_back(int'(bytes[55 - 8*i -: 8]));
        end
        sb.push_back(LD_MARK);
    endtask

    task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bus.bcd_hundreds = h;
        bus.bcd_tens     = t;
        bus.bcd_ones     = o;
    endtask

    // One-cycle request strobe; returns just after the edge that samples it.
    task automatic pulse(input bit s, input bit h);
        bus.send_score = s;
        bus.send_high  = h;
        tick();
        bus.send_score = 1'b0;
        bus.send_high  = 1'b0;
    endtask

    // Wait (bounded) for n line_done pulses, optionally checking busy stays up.
    task automatic wait_lines(input int n, input int budget, input bit busy_hold);
        int seen = 0;
        int c    = 0;
        bit dropped = 1'b0;
        while (seen < n && c < budget) begin
            @(negedge clk);
            c++;
            if (bus.line_done === 1'b1) begin
                seen++;
            end else if (busy_hold && bus.busy !== 1'b1) begin
                dropped = 1'b1;
            end
        end
        chk("lines_in_budget", seen, n);
        if (busy_hold) chk("busy_held", {31'd0, dropped}, 32'd0);
        chk("busy_after_last_line", {31'd0, bus.busy}, 32'd0);
        tick();
        chk("scoreboard_drained", sb.size(), 32'd0);
    endtask

    // Bounded wait for a strobe carrying a given byte.
    task automatic wait_strobe(input logic [7:0] b, input int budget);
        bit found = 1'b0;
        for (int c = 0; c < budget && !found; c++) begin
            @(negedge clk);
            if (bus.txclk === 1'b1 && bus.txdata === b) found = 1'b1;
        end
        chk("strobe_found", {31'd0, found}, 32'd1);
    endtask

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int t0;
        int s0;
        bit any;

        nRst = 1'b0;
        bus.send_score = 1'b0;
        bus.send_high  = 1'b0;
        bus.txready    = 1'b1;
        set_digits(4'd0, 4'd0, 4'd0);
        repeat (3) tick();
        @(negedge clk);
        chk("reset_txdata",    {24'd0, bus.txdata},    32'h00);
        chk("reset_txclk",     {31'd0, bus.txclk},     32'd0);
        chk("reset_busy",      {31'd0, bus.busy},      32'd0);
        chk("reset_line_done", {31'd0, bus.line_done}, 32'd0);
        tick();
        nRst = 1'b1;
        repeat (2) tick();

        // Score line 140 with strobes two cycles apart.
        set_digits(4'd1, 4'd4, 4'd0);
        strobe_cyc.delete();
        ld_cyc.delete();
        push_line(56'h533D3134300D0A);
        pulse(1'b1, 1'b0);
        t0 = cyc;
        chk("busy_after_request", {31'd0, bus.busy}, 32'd1);
        wait_lines(1, 40, 1'b1);
        chk("strobe_count", strobe_cyc.size(), 32'd7);
        if (strobe_cyc.size() == 7 && ld_cyc.size() == 1) begin
            chk("first_strobe_latency", strobe_cyc[0] - t0, 32'd2);
            for (int i = 1; i < 7; i++) begin
                chk("strobe_spacing", strobe_cyc[i] - strobe_cyc[i-1], 32'd2);
            end
            chk("line_done_after_last", ld_cyc[0] - strobe_cyc[6], 32'd1);
        end
        repeat (3) tick();

        // Simultaneous requests: high-score line first, then score line.
        set_digits(4'd0, 4'd0, 4'd7);
        push_line(56'h483D3030370D0A);
        push_line(56'h533D3030370D0A);
        pulse(1'b1, 1'b1);
        wait_lines(2, 60, 1'b1);
        repeat (3) tick();

        // Digits changed after LOAD do not disturb the line in progress.
        set_digits(4'd2, 4'd5, 4'd8);
        push_line(56'h533D3235380D0A);
        pulse(1'b1, 1'b0);
        tick();
        set_digits(4'd9, 4'd9, 4'd9);
        wait_lines(1, 40, 1'b1);
        push_line(56'h533D3939390D0A);
        pulse(1'b1, 1'b0);
        wait_lines(1, 40, 1'b1);
        repeat (3) tick();

        // txready low for 5 cycles while byte index 3 is waiting.
        set_digits(4'd3, 4'd6, 4'd2);
        push_line(56'h533D3336320D0A);
        pulse(1'b1, 1'b0);
        wait_strobe(8'h33, 20);
        tick();
        bus.txready = 1'b0;
        any = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.txclk !== 1'b0) any = 1'b1;
        end
        chk("stall_no_txclk", {31'd0, any}, 32'd0);
        chk("stall_txdata_held", {24'd0, bus.txdata}, 32'h33);
        tick();
        bus.txready = 1'b1;
        wait_lines(1, 40, 1'b1);
        repeat (3) tick();

        // Invalid tens digit and merged repeat requests mid-line.
        set_digits(4'd1, 4'hC, 4'd5);
        push_line(56'h533D313F350D0A);
        push_line(56'h533D313F350D0A);
        pulse(1'b1, 1'b0);
        repeat (3) begin
            repeat (2) tick();
            pulse(1'b1, 1'b0);
        end
        wait_lines(2, 80, 1'b1);
        s0 = strobe_cyc.size();
        repeat (30) tick();
        chk("merged_no_third_line", strobe_cyc.size() - s0, 32'd0);
        chk("merged_idle_busy", {31'd0, bus.busy}, 32'd0);

        // Reset mid-line abandons the line for good.
        set_digits(4'd1, 4'd2, 4'd3);
        push_line(56'h533D3132330D0A);
        pulse(1'b1, 1'b0);
        wait_strobe(8'h32, 20);
        tick();
        nRst = 1'b0;
        sb.delete();
        tick();
        nRst = 1'b1;
        @(negedge clk);
        chk("midreset_txdata",    {24'd0, bus.txdata},    32'h00);
        chk("midreset_txclk",     {31'd0, bus.txclk},     32'd0);
        chk("midreset_busy",      {31'd0, bus.busy},      32'd0);
        chk("midreset_line_done", {31'd0, bus.line_done}, 32'd0);
        s0 = strobe_cyc.size();
        repeat (40) tick();
        chk("midreset_no_resume", strobe_cyc.size() - s0, 32'd0);
        chk("midreset_busy_idle", {31'd0, bus.busy}, 32'd0);

        chk("final_scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
